// File: rtl/dm_bus_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM encoding,
// default sizing and the word-alignment mask.
package dm_bus_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // Default word-address width (byte space is 2^(ADDR_W+2))
  localparam int ADDR_W_DEF  = 10;
  // Default number of REQ cycles allowed without an acknowledge
  localparam int TIMEOUT_DEF = 16;

  // Byte-offset bits that must be zero for a word access
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/bus_timer.sv
// Clear/enable cycle counter with a terminal-count flag raised when the
// count equals TIMEOUT-1. Used to bound how long the bridge waits for ack.
module bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int                 CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Counter: clear has priority over enable; async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tc = (cnt_reg == TC_VAL);

endmodule

// File: rtl/dm_bus_bridge.sv
// Bridge between the multicycle core's data-memory states and a
// variable-latency word SRAM. One request at a time: alignment/range
// check, req/ack handshake with timeout, done/error pulse back to the core.
module dm_bus_bridge
  import dm_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              addr_err,
  output logic              tmo_err
);

  state_t state_reg, state_next;

  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              addr_err_reg;
  logic              tmo_err_reg;

  logic addr_bad;
  logic accept;
  logic reject;
  logic timed_out;
  logic load_ack;
  logic timer_clr;
  logic timer_en;
  logic tc;

  // Misaligned byte offset or any address bit above the SRAM window
  assign addr_bad  = ((cpu_addr & ALIGN_MASK) != 32'd0) ||
                     ((cpu_addr >> (ADDR_W + 2)) != 32'd0);
  assign accept    = (state_reg == ST_IDLE) && cpu_req && !addr_bad;
  assign reject    = (state_reg == ST_IDLE) && cpu_req && addr_bad;
  // Ack on the terminal-count edge still counts as success
  assign timed_out = (state_reg == ST_REQ) && !mem_ack && tc;
  assign load_ack  = (state_reg == ST_REQ) && mem_ack && !we_reg;

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (tc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and timer control; the timer only runs while in REQ
  always_comb begin
    state_next = state_reg;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_req) begin
          state_next = addr_bad ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        timer_clr = 1'b0;
        if (mem_ack) begin
          state_next = ST_DONE;
        end else if (tc) begin
          state_next = ST_ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, load-data capture and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      addr_err_reg <= 1'b0;
      tmo_err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= cpu_we;
        addr_reg  <= cpu_addr[ADDR_W+1:2];
        wdata_reg <= cpu_wdata;
      end
      if (load_ack) begin
        rdata_reg <= mem_rdata;
      end
      if (reject) begin
        addr_err_reg <= 1'b1;
      end
      if (timed_out) begin
        tmo_err_reg <= 1'b1;
      end
    end
  end

  assign mem_req   = (state_reg == ST_REQ);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign cpu_rdata = rdata_reg;
  assign cpu_done  = (state_reg == ST_DONE) || (state_reg == ST_ERR);
  assign cpu_err   = (state_reg == ST_ERR);
  assign busy      = (state_reg != ST_IDLE);
  assign addr_err  = addr_err_reg;
  assign tmo_err   = tmo_err_reg;

endmodule
